scfifo_stream_reader: RTL

- Read-side companion for the single-clock FIFO (ScFifo2).
- Drives the FIFO's registered read port: a `read` strobe, `dout` valid one cycle later, and `empty`.
- Presents the data downstream as a first-word-fall-through valid/ready stream with full one-word-per-cycle throughput.
- Sits between the FIFO and any consumer that needs backpressure. It is the "reader" for the FIFO's write side.

---
 rtl/scfifo_pkg.sv | 7 +
 rtl/scfifo_skid2.sv | 68 ++++++
 rtl/scfifo_stream_reader.sv | 67 ++++++
 3 files changed

// File: rtl/scfifo_pkg.sv
// Shared types and constants for the single-clock FIFO
// read-side stream adapter and its benches.
package scfifo_pkg;
  typedef logic [1:0] occ_t;
  localparam int OCC_MAX = 2;
  localparam int DW_DEF  = 8;
endpackage

// File: rtl/scfifo_skid2.sv
// Two-entry head/skid buffer with push, pop and flush.
// Flush wins over any simultaneous push or pop.
module scfifo_skid2
  import scfifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output occ_t          occ,
  output logic [DW-1:0] head
);

  occ_t          occ_q, occ_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] skid_q, skid_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = 2'd0;
    end else if (push && pop) begin
      if (occ_q == 2'd2) begin
        head_d = skid_q;
        skid_d = din;
      end else begin
        head_d = din;
      end
    end else if (push) begin
      if (occ_q == 2'd0) begin
        head_d = din;
        occ_d  = 2'd1;
      end else if (occ_q == 2'd1) begin
        skid_d = din;
        occ_d  = 2'd2;
      end
    end else if (pop) begin
      if (occ_q == 2'd2) begin
        head_d = skid_q;
        occ_d  = 2'd1;
      end else begin
        occ_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/scfifo_stream_reader.sv
// Turns the FIFO's registered read port into a
// first-word-fall-through valid/ready stream.
module scfifo_stream_reader
  import scfifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_read,
  input  logic          flush,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    occ,
  output logic [CW-1:0] word_cnt
);

  logic          inflight_q, inflight_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          pop;
  logic [2:0]    credit;
  occ_t          occ_w;

  assign m_valid = (occ_w != 2'd0);
  assign pop     = m_valid & m_ready;
  assign occ     = occ_w;

  // Words held plus the one on its way must stay below two
  assign credit = {1'b0, occ_w}
                + {2'b0, inflight_q}
                - {2'b0, pop};

  always_comb begin
    fifo_read  = rst_n & ~fifo_empty & ~flush
               & (credit < 3'(OCC_MAX));
    inflight_d = fifo_read;
    word_cnt_d = word_cnt_q + CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

  scfifo_skid2 #(.DW(DW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_dout),
    .occ   (occ_w),
    .head  (m_data)
  );

endmodule
